// File: rtl/connect4_pkg.sv
// Shared connect-4 definitions: transmit FSM state encoding and board/frame geometry,
// used by the board-display, game FSM and serial transmit blocks.
package connect4_pkg;

  localparam int BOARD_CELLS = 16;
  localparam int FRAME_BITS  = 2 * BOARD_CELLS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_e;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Owner mask occupies the upper half so it leaves the shift chain first.
  function automatic frame_t pack_frame(input logic [BOARD_CELLS-1:0] owner,
                                        input logic [BOARD_CELLS-1:0] occupied);
    return {owner, occupied};
  endfunction

endpackage

// File: rtl/board_shift_tx.sv
// Serialises the 32-bit board frame {player_cells, gameboard} MSB first into an external
// shift-register chain (ser_data/ser_clk) and strobes its storage register (ser_latch).
module board_shift_tx
  import connect4_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4  // clk cycles per ser_clk half-period, 1..255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_CELLS-1:0] gameboard,
  input  logic [BOARD_CELLS-1:0] player_cells,
  input  logic                   send,
  input  logic                   auto_en,
  output logic                   busy,
  output logic                   done,
  output logic                   ser_data,
  output logic                   ser_clk,
  output logic                   ser_latch
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [5:0] bit_q, bit_d;
  logic       phase_q, phase_d;  // 0: ser_clk low half, 1: ser_clk high half
  frame_t     shreg_q, shreg_d;
  frame_t     last_sent_q, last_sent_d;
  logic       pending_q, pending_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ser_data_q, ser_data_d;
  logic ser_clk_q, ser_clk_d;
  logic ser_latch_q, ser_latch_d;

  frame_t frame_now;
  logic   div_wrap;
  logic   board_changed;

  assign frame_now     = pack_frame(player_cells, gameboard);
  assign div_wrap      = (div_q == DIV_LAST);
  assign board_changed = (frame_now != last_sent_q);

  // NOTE: every register here is updated with <= so all of them sample the same
  // pre-edge values; a blocking = would let later statements see half-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      shreg_q     <= '0;
      last_sent_q <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      shreg_q     <= shreg_d;
      last_sent_q <= last_sent_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ser_data_q  <= ser_data_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
    end
  end

  // NOTE: each variable gets a hold default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    shreg_d     = shreg_q;
    last_sent_d = last_sent_q;
    pending_d   = pending_q;

    if (send && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end
    if (auto_en && board_changed && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (send || pending_q) begin
          state_d = ST_LOAD;
        end
      end

      // The snapshot taken here satisfies any request that arrives alongside it.
      ST_LOAD: begin
        shreg_d     = frame_now;
        last_sent_d = frame_now;
        pending_d   = 1'b0;
        div_d       = '0;
        bit_d       = '0;
        phase_d     = 1'b0;
        state_d     = ST_SHIFT;
      end

      ST_SHIFT: begin
        div_d = div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) begin
          phase_d = ~phase_q;
          // Advance only after the high half, so new data lands at the start of a low half.
          if (phase_q) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = ST_LATCH;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end
      end

      ST_LATCH: begin
        div_d = div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = pending_q ? ST_LOAD : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state values and registered, so they line up with state_q.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    ser_clk_d   = (state_d == ST_SHIFT) && phase_d;
    ser_latch_d = (state_d == ST_LATCH);
    ser_data_d  = (state_d == ST_SHIFT) ? shreg_d[FRAME_BITS-1] : 1'b0;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ser_data  = ser_data_q;
  assign ser_clk   = ser_clk_q;
  assign ser_latch = ser_latch_q;

endmodule

// File: tb/tb_board_shift_tx.sv
// Scoreboard bench for board_shift_tx: a CLK_DIV=4 and a CLK_DIV=1 instance, each watched by
// a shift-register model that compares latched frames against queued expectations.
module tb_board_shift_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gameboard;
  logic [15:0] player_cells;
  logic [1:0]  send;
  logic [1:0]  auto_en;
  logic [1:0]  busy, done, ser_data, ser_clk, ser_latch;

  int n_tests = 0;
  int n_fail  = 0;

  int rises    [2];
  int latches  [2];
  int dones    [2];
  int busy_cyc [2];

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk = ~clk;

  board_shift_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .gameboard(gameboard), .player_cells(player_cells),
    .send(send[0]), .auto_en(auto_en[0]), .busy(busy[0]), .done(done[0]),
    .ser_data(ser_data[0]), .ser_clk(ser_clk[0]), .ser_latch(ser_latch[0])
  );

  board_shift_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .gameboard(gameboard), .player_cells(player_cells),
    .send(send[1]), .auto_en(auto_en[1]), .busy(busy[1]), .done(done[1]),
    .ser_data(ser_data[1]), .ser_clk(ser_clk[1]), .ser_latch(ser_latch[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  function automatic bit pop_exp(input int g, output logic [31:0] f);
    f = '0;
    if (g == 0) begin
      if (exp_q0.size() == 0) return 1'b0;
      f = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) return 1'b0;
      f = exp_q1.pop_front();
    end
    return 1'b1;
  endfunction

  // External chain model: samples ser_data on each ser_clk rise, checks on ser_latch fall.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int D = (g == 0) ? 4 : 1;
    logic [31:0] sh, exp_v;
    int          nbits, cyc, latch_len, nlatch;
    logic        sclk_p, slatch_p, busy_p, done_p;
    bit          have;

    always @(negedge clk) begin
      if (!reset) begin
        sh = '0; nbits = 0; cyc = 0; latch_len = 0; nlatch = 0;
        sclk_p = 1'b0; slatch_p = 1'b0; busy_p = 1'b0; done_p = 1'b0;
      end else begin
        if (busy[g] && (!busy_p || done_p)) begin
          cyc = 1; nbits = 0; latch_len = 0; nlatch = 0;
        end else if (busy[g]) begin
          cyc++;
        end
        if (busy[g]) busy_cyc[g]++;
        if (ser_clk[g] && !sclk_p) begin
          sh = {sh[30:0], ser_data[g]};
          nbits++;
          rises[g]++;
        end
        if (ser_latch[g]) latch_len++;
        if (!ser_latch[g] && slatch_p) begin
          latches[g]++;
          nlatch++;
          check($sformatf("latch_width%0d", g), 32'(latch_len), 32'(D));
          check($sformatf("bit_count%0d", g), 32'(nbits), 32'd32);
          have = pop_exp(g, exp_v);
          check($sformatf("frame_expected%0d", g), 32'(have), 32'd1);
          if (have) check($sformatf("frame_data%0d", g), sh, exp_v);
          latch_len = 0;
        end
        if (done[g]) begin
          dones[g]++;
          check($sformatf("latency%0d", g), 32'(cyc), 32'(2 + 65 * D));
          check($sformatf("latch_per_frame%0d", g), 32'(nlatch), 32'd1);
        end
        sclk_p = ser_clk[g]; slatch_p = ser_latch[g]; busy_p = busy[g]; done_p = done[g];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_send(input int g);
    send[g] = 1'b1;
    tick();
    send[g] = 1'b0;
  endtask

  task automatic wait_dones(input int g, input int target, input int budget);
    int n = 0;
    while (dones[g] < target && n < budget) begin
      tick();
      n++;
    end
    if (dones[g] < target) check($sformatf("timeout_done%0d", g), 32'(dones[g]), 32'(target));
  endtask

  task automatic wait_rises(input int g, input int target, input int budget);
    int n = 0;
    while (rises[g] < target && n < budget) begin
      tick();
      n++;
    end
    if (rises[g] < target) check($sformatf("timeout_rise%0d", g), 32'(rises[g]), 32'(target));
  endtask

  function automatic logic [31:0] outs(input int g);
    return {27'd0, busy[g], done[g], ser_data[g], ser_clk[g], ser_latch[g]};
  endfunction

  initial begin
    int d0, d1, r0, l0, b0, b1, ok;

    reset = 1'b0; gameboard = '0; player_cells = '0; send = '0; auto_en = '0;
    repeat (3) tick();
    check("reset_outs4", outs(0), 32'd0);
    check("reset_outs1", outs(1), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Single frame at CLK_DIV=4.
    gameboard = 16'hA5C3; player_cells = 16'h0F0F;
    exp_q0.push_back(32'h0F0FA5C3);
    d0 = dones[0]; l0 = latches[0];
    pulse_send(0);
    wait_dones(0, d0 + 1, 400);
    check("one_latch", 32'(latches[0] - l0), 32'd1);
    tick();
    check("idle_after_frame", 32'(busy[0]), 32'd0);

    // Second send at bit 10 queues exactly one back-to-back frame.
    gameboard = 16'h1111; player_cells = 16'h2222;
    exp_q0.push_back(32'h22221111);
    d0 = dones[0]; r0 = rises[0];
    pulse_send(0);
    wait_rises(0, r0 + 10, 400);
    gameboard = 16'h3333; player_cells = 16'h4444;
    exp_q0.push_back(32'h44443333);
    pulse_send(0);
    wait_dones(0, d0 + 1, 400);
    tick();
    check("b2b_load_busy", 32'(busy[0]), 32'd1);
    check("b2b_done_low", 32'(done[0]), 32'd0);
    wait_dones(0, d0 + 2, 400);
    repeat (3) tick();
    check("idle_after_b2b", 32'(busy[0]), 32'd0);

    // Automatic retransmission on board change.
    auto_en[0] = 1'b1;
    d0 = dones[0];
    gameboard = 16'h0001; player_cells = 16'h0000;
    exp_q0.push_back(32'h00000001);
    wait_dones(0, d0 + 1, 400);
    repeat (5) tick();
    gameboard = 16'h0003;
    exp_q0.push_back(32'h00000003);
    wait_dones(0, d0 + 2, 400);
    b0 = busy_cyc[0];
    repeat (20) tick();
    check("auto_quiet", 32'(busy_cyc[0] - b0), 32'd0);
    auto_en[0] = 1'b0;

    // Board changes without auto_en or send must not start a frame.
    r0 = rises[0]; b0 = busy_cyc[0]; b1 = busy_cyc[1];
    for (int i = 0; i < 10; i++) begin
      gameboard = 16'($urandom); player_cells = 16'($urandom);
      repeat (10) tick();
    end
    check("noauto_busy4", 32'(busy_cyc[0] - b0), 32'd0);
    check("noauto_busy1", 32'(busy_cyc[1] - b1), 32'd0);
    check("noauto_sclk", 32'(rises[0] - r0), 32'd0);

    // CLK_DIV=1: ser_clk toggles every clk.
    gameboard = 16'hBEEF; player_cells = 16'hC0DE;
    exp_q1.push_back(32'hC0DEBEEF);
    d1 = dones[1];
    pulse_send(1);
    check("div1_load", 32'(busy[1]), 32'd1);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (ser_clk[1] == i[0]) ok++;
    end
    check("div1_toggle", 32'(ok), 32'd64);
    wait_dones(1, d1 + 1, 100);

    // Asynchronous reset at bit 20 aborts without a latch pulse.
    gameboard = 16'hFFFF; player_cells = 16'hFFFF;
    l0 = latches[0]; r0 = rises[0];
    pulse_send(0);
    wait_rises(0, r0 + 20, 400);
    check("pre_reset_outs", outs(0), 32'b10110);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", outs(0), 32'd0);
    repeat (4) tick();
    reset = 1'b1;
    b0 = busy_cyc[0];
    repeat (40) tick();
    check("idle_after_reset", outs(0), 32'd0);
    check("no_busy_after_reset", 32'(busy_cyc[0] - b0), 32'd0);
    check("no_latch_on_abort", 32'(latches[0] - l0), 32'd0);

    // A fresh send after reset still works.
    gameboard = 16'h1234; player_cells = 16'h5678;
    exp_q0.push_back(32'h56781234);
    d0 = dones[0];
    pulse_send(0);
    wait_dones(0, d0 + 1, 400);
    repeat (3) tick();

    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_shift_tx.md
BOARD_SHIFT_TX -- requirements
Module: board_shift_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per ser_clk half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port gameboard  input  16  occupied-cell mask of the board.
REQ-005 SHALL have port player_cells  input  16  owner mask of the board (1 = player 2).
REQ-006 SHALL have port send  input  1  transmit request, sampled each clk.
REQ-007 SHALL have port auto_en  input  1  when 1, a board change triggers retransmission.
REQ-008 SHALL have port busy  output  1  frame in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port ser_data  output  1  serial data to the external shift-register chain.
REQ-011 SHALL have port ser_clk  output  1  shift clock; the external chain samples on its rising edge.
REQ-012 SHALL have port ser_latch  output  1  storage-register latch strobe, active-high.

Function
REQ-013 SHALL define the frame as 32 bits, {player_cells, gameboard}, shifted MSB first (player_cells[15] first, gameboard[0] last).
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH, DONE.
REQ-015 SHALL move from IDLE to LOAD on the first clk where send=1 or pending=1.
REQ-016 SHALL, in LOAD (exactly one cycle), capture the frame into the shift register and into last_sent, clear pending, and assert busy.
REQ-017 SHALL hold busy=1 from LOAD through DONE inclusive, and 0 in IDLE.
REQ-018 SHALL, in SHIFT, drive each bit as CLK_DIV cycles with ser_clk=0 followed by CLK_DIV cycles with ser_clk=1.
REQ-019 SHALL change ser_data only at the start of each ser_clk low phase, so data is stable across each rising edge.
REQ-020 SHALL count exactly 32 bits with a 6-bit bit counter, then enter LATCH.
REQ-021 SHALL, in LATCH, hold ser_clk=0 and ser_latch=1 for CLK_DIV cycles; ser_latch SHALL be 0 in all other states.
REQ-022 SHALL, in DONE (one cycle), pulse done=1, then go to LOAD if pending=1, else to IDLE.
REQ-023 SHALL make the frame latency, from LOAD to DONE inclusive, 1 + 64*CLK_DIV + CLK_DIV + 1 cycles (262 cycles at CLK_DIV=4).
REQ-024 SHALL set pending when send=1 arrives while busy=1; multiple such requests collapse into one.
REQ-025 SHALL set pending when auto_en=1, state is IDLE or DONE, and the current {player_cells, gameboard} differs from last_sent.
REQ-026 SHALL, when send and a change are simultaneous with LOAD, not set pending, because the LOAD capture wins.
REQ-027 SHALL ignore input changes during SHIFT for the frame in flight, which uses the LOAD snapshot.
REQ-028 SHALL use a half-period divider counter of 8 bits that wraps to 0 at CLK_DIV-1.

Reset
REQ-029 SHALL, while reset=0, force state=IDLE, busy=0, done=0, ser_data=0, ser_clk=0, ser_latch=0, pending=0, last_sent=0, and all counters to 0, independent of clk.
REQ-030 SHALL, on reset mid-frame, abort without a latch pulse; after release it resumes with idle outputs and requires a new send.

Structure
REQ-031 SHALL take the state encoding (3-bit) and FRAME_BITS=32 from the shared connect4 package, which the board-display and FSM blocks also use.
REQ-032 SHALL be one module with no sub-modules; the divider is inline.
REQ-033 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification
REQ-034 SHALL cover: gameboard=16'hA5C3, player_cells=16'h0F0F, one-cycle send -> the bench shift-register model captures 32'h0F0FA5C3, one ser_latch pulse, done at 262 cycles after LOAD.
REQ-035 SHALL cover: send asserted again at bit 10 of a frame -> exactly one extra frame immediately after DONE (LOAD on the cycle following done).
REQ-036 SHALL cover: auto_en=1, gameboard changes 16'h0001->16'h0003 while idle -> a new frame 32'h00000003 sent without send.
REQ-037 SHALL cover: reset=0 at bit 20 -> all outputs 0 asynchronously, no ser_latch pulse, and IDLE after release.
REQ-038 SHALL cover: CLK_DIV=1 -> ser_clk toggles every clk, frame length 67 cycles, data correct.
REQ-039 SHALL cover: auto_en=0 with a changing board and no send -> busy stays 0 and no ser_clk edges occur.
